// File: rtl/bp_trace_replay_mc.sv
// bp_trace_replay_mc: replays a trace ROM of NOP/SEND/RECV/WAIT/DONE entries against channels_p DUT channels.
// Latency: one entry per cycle when handshakes complete at once; WAIT n occupies n+1 cycles in WAIT.
// Backpressure: SEND holds v_o until yumi_i, RECV holds ready_o until v_i. Defining the macro
// BP_TRACE_REPLAY_TIMEOUT_EN adds a watchdog that ends a replay stalled for timeout_p cycles.
module bp_trace_replay_mc #(
  parameter int payload_width_p  = 64,
  parameter int channels_p       = 2,
  parameter int rom_addr_width_p = 7,
  parameter int wait_width_p     = 16,
  parameter int timeout_p        = 4096,
  localparam int chid_w  = (channels_p == 1) ? 1 : $clog2(channels_p),
  localparam int entry_w = 4 + chid_w + payload_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  en_i,
  output logic [rom_addr_width_p-1:0]           rom_addr_o,
  input  logic [entry_w-1:0]                    rom_data_i,
  output logic [channels_p-1:0]                 v_o,
  output logic [payload_width_p-1:0]            data_o,
  input  logic [channels_p-1:0]                 yumi_i,
  input  logic [channels_p-1:0]                 v_i,
  input  logic [channels_p*payload_width_p-1:0] data_i,
  output logic [channels_p-1:0]                 ready_o,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic [15:0]                           err_count_o,
  output logic                                  timeout_o
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_e;

  localparam logic [3:0] op_nop_c  = 4'd0;
  localparam logic [3:0] op_send_c = 4'd1;
  localparam logic [3:0] op_recv_c = 4'd2;
  localparam logic [3:0] op_wait_c = 4'd3;
  localparam logic [3:0] op_done_c = 4'd4;

  state_e                      state_q;
  logic [rom_addr_width_p-1:0] ptr_q;
  logic [wait_width_p-1:0]     wait_q;
  logic                        error_q;
  logic [15:0]                 err_count_q, err_count_d;

  // Entry fields, decoded straight from the ROM word at the current pointer.
  logic [3:0]                 op;
  logic [chid_w-1:0]          chan;
  logic [payload_width_p-1:0] payload;
  assign {op, chan, payload} = rom_data_i;

  logic exec_w, chan_ok_w, send_w, recv_w, hs_w, stall_w;
  logic bad_w, mis_w, adv_w, wrap_w, to_w, err_ev_w;
  logic [payload_width_p-1:0] rx_w;
  logic [1:0]                 err_inc_w;
  logic [16:0]                err_sum_w;

  assign exec_w    = (state_q == EXEC);
  // The channel field only matters for SEND/RECV, so only those can name a missing channel.
  assign chan_ok_w = (int'(chan) < channels_p);
  assign send_w    = exec_w && (op == op_send_c) && chan_ok_w;
  assign recv_w    = exec_w && (op == op_recv_c) && chan_ok_w;
  assign rx_w      = data_i[int'(chan)*payload_width_p +: payload_width_p];
  assign hs_w      = (send_w && yumi_i[chan]) || (recv_w && v_i[chan]);
  assign stall_w   = (send_w || recv_w) && !hs_w;
  assign bad_w     = exec_w && ((op > op_done_c) ||
                     (((op == op_send_c) || (op == op_recv_c)) && !chan_ok_w));
  assign mis_w     = recv_w && v_i[chan] && (rx_w != payload);
  assign adv_w     = (exec_w && ((op == op_nop_c) || bad_w || hs_w)) ||
                     ((state_q == WAIT) && (wait_q == '0));
  // Running off the end of the ROM means the trace lacked a DONE entry.
  assign wrap_w    = adv_w && (ptr_q == '1);

  // Several error sources can coincide (e.g. a bad entry in the last slot); count each once.
  assign err_inc_w   = 2'(bad_w) + 2'(mis_w) + 2'(wrap_w) + 2'(to_w);
  assign err_ev_w    = (err_inc_w != 2'd0);
  assign err_sum_w   = {1'b0, err_count_q} + {15'b0, err_inc_w};
  assign err_count_d = err_sum_w[16] ? 16'hFFFF : err_sum_w[15:0];

`ifdef BP_TRACE_REPLAY_TIMEOUT_EN
  localparam int stall_bits_lp = $clog2(timeout_p + 1);
  logic [stall_bits_lp-1:0] stall_q;
  logic                     timeout_q;

  assign to_w      = stall_w && (stall_q == stall_bits_lp'(timeout_p - 1));
  assign timeout_o = timeout_q;

  // Watchdog: count consecutive stalled SEND/RECV cycles; any other cycle restarts the count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q <= stall_w ? stall_q + 1'b1 : '0;
      if (to_w) timeout_q <= 1'b1;
    end
  end
`else
  assign to_w      = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Replay sequencer: state, entry pointer, wait counter and sticky error bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      error_q     <= error_q | err_ev_w;
      err_count_q <= err_count_d;
      if (adv_w) ptr_q <= ptr_q + 1'b1;
      case (state_q)
        IDLE: if (en_i) state_q <= EXEC;
        EXEC: begin
          if (to_w || (op == op_done_c)) begin
            state_q <= DONE;
          end else if (op == op_wait_c) begin
            wait_q  <= payload[wait_width_p-1:0];
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wait_q == '0) state_q <= EXEC;
          else              wait_q  <= wait_q - 1'b1;
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the decoded channel of a live SEND/RECV is driven; all other bits and data stay 0.
  always_comb begin
    v_o     = '0;
    ready_o = '0;
    data_o  = '0;
    if (send_w) begin
      v_o[chan] = 1'b1;
      data_o    = payload;
    end
    if (recv_w) ready_o[chan] = 1'b1;
  end

  assign rom_addr_o  = ptr_q;
  assign error_o     = error_q;
  assign err_count_o = err_count_q;
  // done_o rises as soon as a DONE entry is decoded and then holds from the DONE state.
  assign done_o      = (state_q == DONE) || (exec_w && (op == op_done_c));

endmodule
